ps2_device: RTL and testbench
=============================

# ps2_device

PS/2 device-side (keyboard-end) protocol engine. It generates the PS/2 clock, serialises device-to-host bytes (scan codes, `FA` ACK, `AA` self-test), and receives host-to-device command bytes (`ED`, `F4`, LED params) with the line-level acknowledge. It is the counterpart of the host-side `ps2_receiver`/`Keyboard` path. It is used as a keyboard model in simulation and on-board loopback tests, and as the front end of a future emulated keyboard. Both PS/2 lines are open-drain: the block only ever drives low or releases.

## Interface
- `CLK_HALF`, 400: `clk` cycles per PS/2 clock half-period (15 kHz at 12 MHz).
- `IDLE_MIN`, 600: `clk` cycles both lines must read high before a transmit may start.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk_in`  in  1  PS/2 clock line level (asynchronous).
- `ps2_data_in`  in  1  PS/2 data line level (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull clock line low.
- `ps2_data_oe`  out  1  1 = pull data line low.
- `tx_valid`  in  1  byte offered for device-to-host transmission.
- `tx_data`  in  8  byte to send.
- `tx_ready`  out  1  accept; transfer when `tx_valid && tx_ready`.
- `tx_done`  out  1  one-cycle pulse when a frame completes without abort.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` holds a good host byte.
- `rx_data`  out  8  last received byte; holds until the next `rx_valid`.
- `rx_error`  out  1  one-cycle pulse on a parity or stop-bit failure.

## Operation
- Both line inputs pass through 2-FF synchronisers. All line decisions use the synchronised values `sclk` and `sdat`.
- Frame format: start 0, d0..d7 LSB first, odd parity, stop 1.
- One-entry pending buffer:
  - `tx_ready = (state==IDLE) && !pending`.
  - An accepted byte sets `pending` and is retained until its frame completes.
- IDLE:
  - Releases both lines.
  - Counts consecutive cycles with `sclk && sdat`; any low resets the count.
- Request-to-send: `sclk==1 && sdat==0` in IDLE enters RX. It has priority over a pending TX, which stays pending.
- TX start: entered when `pending` is set and the idle count is ≥ `IDLE_MIN`.
- TX sequence:
  - TX_SETUP (H cycles): drive the start bit, clock released.
  - Then 11 pulses of TX_LOW (clock driven, H cycles) followed by TX_HIGH (released, H cycles).
  - Data for bit k+1 changes H/2 cycles into the high phase that follows pulse k.
  - After the 11th high phase: release data, clear `pending`, pulse `tx_done`, return to IDLE.
- TX abort (host inhibit): `sclk==0` sampled on the last cycle of any TX_HIGH that precedes the 11th falling edge.
  - Release both lines next cycle and go to IDLE.
  - `pending` is kept; the retransmit is the whole frame, once the idle rule is met again.
  - After the 11th falling edge, inhibit is ignored.
- RX sequence:
  - RX_WAIT (H cycles).
  - Then 11 clock pulses (low H, high H).
  - `sdat` is sampled H/2 cycles into the high phase of pulses 1-10: d0..d7, parity, stop.
  - During the high phase after pulse 10, the block evaluates the frame.
- RX good frame (stop == 1 and odd parity across d0..d7 plus parity):
  - Drive data low (ack) for pulse 11 and its following high phase, then release.
  - Load `rx_data` and pulse `rx_valid` on the cycle of return to IDLE.
- RX bad frame: no ack; data stays released for pulse 11; pulse `rx_error` on return to IDLE.
- RX abort: `sclk==0` at the end of an RX high phase. Go to IDLE with no `rx_valid` and no `rx_error`.

## Timing
- Reset values:
  - `ps2_clk_oe`, `ps2_data_oe`, `tx_done`, `rx_valid`, `rx_error` = 0.
  - `rx_data` = 0; `pending` = 0; idle count = 0; state = IDLE.
  - `tx_ready` = 1 from the first cycle after reset is released.
- Reset mid-frame: both lines are released on the cycle after `rst` is sampled; the pending byte is discarded.
- A TX frame takes (1 + 22)·H cycles from TX start to `tx_done`, i.e. 9200 cycles at the defaults.
- An RX frame takes 23·H cycles from request detection to `rx_valid`/`rx_error`, plus 2 cycles of synchroniser latency before detection.
- Acceptance: `tx_valid` may be held or withdrawn freely; the byte is captured only on the handshake cycle.
- All outputs are registered; there is no combinational path from the line inputs to the line outputs.

## Test plan
- Send `1C` (`CLK_HALF`=4, `IDLE_MIN`=6):
  - The host model samples on clock falling edges and sees 0, 0,0,1,1,1,0,0,0, parity 0, stop 1.
  - `tx_done` pulses 92 cycles after start; `tx_ready` returns to 1.
- Host sends `ED` (parity 1, stop 1):
  - Device generates 11 pulses and drives ack low during pulse 11.
  - `rx_valid` pulses with `rx_data=ED`.
- Host sends `ED` with parity 0 → no ack, `rx_error` pulses, `rx_data` unchanged.
- Host pulls clock low during the 5th TX pulse of `AA`:
  - Lines are released and the frame aborts.
  - After the lines idle for `IDLE_MIN`, the full `AA` frame is resent, then `tx_done` pulses once.
- Priority: `tx_valid` with `FA` presented in the same cycle a request-to-send appears:
  - The RX of `F4` completes first.
  - `FA` is then transmitted.
- Assert `rst` mid-RX → both `oe` outputs are 0 next cycle, no `rx_valid`/`rx_error`, `tx_ready`=1.

Source files
------------

// File: rtl/ps2_device.sv
// PS/2 device-side protocol engine: generates the PS/2 clock, sends device-to-host
// frames from a one-entry pending buffer and receives host-to-device frames with
// the line-level acknowledge. Both lines are open-drain (drive low or release).
// CLK_HALF must be at least 4 so the stop-bit sample lands before frame evaluation.
module ps2_device #(
  parameter int unsigned CLK_HALF = 400,
  parameter int unsigned IDLE_MIN = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_error
);

  localparam int unsigned CW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int unsigned IW = $clog2(IDLE_MIN + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] HALF_MID  = CW'(CLK_HALF / 2 - 1);
  localparam logic [CW-1:0] HALF_SAMP = CW'(CLK_HALF / 2);
  localparam logic [IW-1:0] IDLE_MIN_C = IW'(IDLE_MIN);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_SETUP, S_TX_LOW, S_TX_HIGH, S_RX_WAIT, S_RX_LOW, S_RX_HIGH
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_bit;
  logic [IW-1:0]   r_idle_cnt;
  logic            r_pending;
  logic [7:0]      r_tx_byte;
  logic [9:0]      r_rx_bits;
  logic [7:0]      r_rx_data;
  logic            r_clk_oe, r_data_oe;
  logic            r_tx_ready, r_tx_done, r_rx_valid, r_rx_error;
  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_doe_d1, r_doe_d2;

  logic            w_sclk, w_sdat, w_own_low, w_half_end, w_hs, w_rx_good;
  logic [10:0]     w_frame;

  assign w_sclk     = r_clk_s2;
  assign w_sdat     = r_dat_s2;
  // Our own released data drive is still visible through the synchroniser for two cycles.
  assign w_own_low  = r_doe_d1 | r_doe_d2;
  assign w_half_end = (r_cnt == HALF_LAST);
  assign w_hs       = tx_valid & r_tx_ready;
  assign w_frame    = {1'b1, ~^r_tx_byte, r_tx_byte, 1'b0};
  assign w_rx_good  = r_rx_bits[9] & (^r_rx_bits[8:0]);

  // Two-flop synchronisers for the line inputs plus a history of our data drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_doe_d1 <= 1'b0;
      r_doe_d2 <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_in;
      r_dat_s2 <= r_dat_s1;
      r_doe_d1 <= r_data_oe;
      r_doe_d2 <= r_doe_d1;
    end
  end

  // Protocol FSM: idle qualification, TX/RX bit sequencing, pending buffer and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_idle_cnt <= '0;
      r_pending  <= 1'b0;
      r_tx_byte  <= '0;
      r_rx_bits  <= '0;
      r_rx_data  <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_tx_ready <= 1'b1;
      r_tx_done  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_error <= 1'b0;
    end else begin
      r_tx_done  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_error <= 1'b0;
      r_idle_cnt <= '0;
      if (w_hs) begin
        r_pending <= 1'b1;
        r_tx_byte <= tx_data;
      end
      case (r_state)
        S_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_cnt     <= '0;
          r_bit     <= '0;
          if (w_sclk && w_sdat && (r_idle_cnt != IDLE_MIN_C))
            r_idle_cnt <= r_idle_cnt + IW'(1);
          else if (w_sclk && w_sdat)
            r_idle_cnt <= r_idle_cnt;
          if (w_sclk && !w_sdat && !w_own_low) begin
            r_state    <= S_RX_WAIT;
            r_tx_ready <= 1'b0;
          end else if (r_pending && (r_idle_cnt >= IDLE_MIN_C)) begin
            r_state    <= S_TX_SETUP;
            r_data_oe  <= 1'b1;
            r_tx_ready <= 1'b0;
          end else begin
            r_tx_ready <= ~(r_pending | w_hs);
          end
        end
        S_TX_SETUP, S_TX_LOW, S_RX_WAIT, S_RX_LOW: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_half_end) begin
            r_cnt    <= '0;
            r_clk_oe <= (r_state != S_TX_LOW) && (r_state != S_RX_LOW);
            case (r_state)
              S_TX_SETUP: r_state <= S_TX_LOW;
              S_TX_LOW:   r_state <= S_TX_HIGH;
              S_RX_WAIT:  r_state <= S_RX_LOW;
              default:    r_state <= S_RX_HIGH;
            endcase
          end
        end
        S_TX_HIGH: begin
          r_cnt <= r_cnt + CW'(1);
          if ((r_cnt == HALF_MID) && (r_bit != 4'd10))
            r_data_oe <= ~w_frame[r_bit + 4'd1];
          if (w_half_end) begin
            r_cnt <= '0;
            if (r_bit == 4'd10) begin
              r_state    <= S_IDLE;
              r_data_oe  <= 1'b0;
              r_pending  <= 1'b0;
              r_tx_done  <= 1'b1;
              r_tx_ready <= 1'b1;
            end else if (!w_sclk) begin
              // Host inhibit: abandon the frame, keep the byte for a full resend.
              r_state   <= S_IDLE;
              r_clk_oe  <= 1'b0;
              r_data_oe <= 1'b0;
            end else begin
              r_bit    <= r_bit + 4'd1;
              r_state  <= S_TX_LOW;
              r_clk_oe <= 1'b1;
            end
          end
        end
        S_RX_HIGH: begin
          r_cnt <= r_cnt + CW'(1);
          if ((r_cnt == HALF_SAMP) && (r_bit != 4'd10))
            r_rx_bits[r_bit] <= w_sdat;
          if (w_half_end) begin
            r_cnt <= '0;
            if (!w_sclk || (r_bit == 4'd10)) begin
              r_state    <= S_IDLE;
              r_data_oe  <= 1'b0;
              r_tx_ready <= ~r_pending;
              if (w_sclk && w_rx_good) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_rx_bits[7:0];
              end else if (w_sclk) begin
                r_rx_error <= 1'b1;
              end
            end else begin
              r_bit    <= r_bit + 4'd1;
              r_state  <= S_RX_LOW;
              r_clk_oe <= 1'b1;
              if (r_bit == 4'd9)
                r_data_oe <= w_rx_good;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx_ready    = r_tx_ready;
  assign tx_done     = r_tx_done;
  assign rx_valid    = r_rx_valid;
  assign rx_data     = r_rx_data;
  assign rx_error    = r_rx_error;

endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: a host model drives the open-drain lines, a vector table
// (fixed cases plus random ones) is checked against a frame-level reference model.
module tb_ps2_device;

  localparam int H    = 4;
  localparam int IMIN = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_clk = 1'b1;
  logic       host_dat = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, rx_valid, rx_error;
  logic [7:0] rx_data;
  wire        line_clk = host_clk & ~ps2_clk_oe;
  wire        line_dat = host_dat & ~ps2_data_oe;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_device #(.CLK_HALF(H), .IDLE_MIN(IMIN)) dut (
    .clk(clk), .rst(rst), .ps2_clk_in(line_clk), .ps2_data_in(line_dat),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         is_rx;
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    int         inh;
    bit         offer;
    logic [7:0] txb;
    bit         exp_ok;
    logic [10:0] exp_fr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: a device-to-host frame as the host sees it, bit 0 first.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  // Offer a byte and return on the half cycle after the handshake edge.
  task automatic tx_send(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (tx_ready) begin
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  // Host receiver: sample data on each falling clock, optionally inhibit after pulse inh.
  task automatic dev_frame(input int inh, output logic [10:0] fr, output int nb,
                           output int lat, output int nd, output bit rel_ok, output bit rdy);
    bit prev_c, prev_d;
    int st, n, inh_l;
    fr = '0; nb = 0; lat = -1; nd = 0; st = -1; n = 0; rel_ok = 1'b0; rdy = 1'b0;
    inh_l = inh;
    prev_c = line_clk;
    prev_d = ps2_data_oe;
    for (int cyc = 1; cyc <= 60 * H + 4 * IMIN + 200; cyc++) begin
      @(negedge clk);
      if (!prev_d && ps2_data_oe && n == 0 && st < 0) st = cyc;
      if (prev_c && !line_clk) begin
        if (n < 11) fr[n] = line_dat;
        n++;
        if (inh_l != 0 && n == inh_l) begin
          host_clk = 1'b0;
          repeat (20) @(negedge clk);
          rel_ok = !ps2_clk_oe && !ps2_data_oe;
          host_clk = 1'b1;
          n = 0; st = -1; inh_l = 0;
          cyc += 20;
        end
      end
      if (tx_done) begin
        nd++;
        lat = cyc - st;
        nb  = n;
        rdy = tx_ready;
        @(negedge clk);
        if (tx_done) nd++;
        break;
      end
      prev_c = line_clk;
      prev_d = ps2_data_oe;
    end
  endtask

  // Host transmitter: request-to-send, then change data on each device falling clock.
  task automatic host_send(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                           input bit offer, input logic [7:0] txb, output int nf,
                           output bit ack, output bit gv, output bit ge, output int lat,
                           output bit rdy_ok, output bit pulse_ok);
    bit prev_c;
    nf = 0; ack = 1'b0; gv = 1'b0; ge = 1'b0; lat = -1; rdy_ok = 1'b0; pulse_ok = 1'b0;
    @(negedge clk);
    host_clk = 1'b0;
    repeat (2 * H) @(negedge clk);
    host_dat = 1'b0;
    repeat (H) @(negedge clk);
    host_clk = 1'b1;
    prev_c = 1'b1;
    for (int cyc = 1; cyc <= 30 * H + 20; cyc++) begin
      @(negedge clk);
      if (offer && cyc == 2) begin
        rdy_ok   = tx_ready;
        tx_data  = txb;
        tx_valid = 1'b1;
      end
      if (offer && cyc == 3) begin
        tx_valid = 1'b0;
        tx_data  = ~txb;
      end
      if (prev_c && !line_clk) begin
        nf++;
        if (nf <= 8) host_dat = d[nf-1];
        else if (nf == 9) host_dat = (~^d) ^ bad_par;
        else if (nf == 10) host_dat = ~bad_stop;
        else if (nf == 11) begin
          ack = ps2_data_oe;
          host_dat = 1'b1;
        end
      end
      if (rx_valid || rx_error) begin
        gv = rx_valid; ge = rx_error; lat = cyc;
        @(negedge clk);
        pulse_ok = !rx_valid && !rx_error;
        break;
      end
      prev_c = line_clk;
    end
    host_dat = 1'b1;
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] last_rx;
    logic [10:0] fr;
    int nb, lat, nd, nf, hits, falls;
    bit ok, rel, rdy, ack, gv, ge, rdy_ok, pulse_ok, prev_c;
    vec_t v;

    // Fixed cases from the test plan, then randomized traffic.
    vecs.push_back('{0, 8'h1C, 0, 0, 0, 0, 8'h00, 1, 11'b10000111000});
    vecs.push_back('{1, 8'hED, 0, 0, 0, 0, 8'h00, 1, 11'b0});
    vecs.push_back('{1, 8'hED, 1, 0, 0, 0, 8'h00, 0, 11'b0});
    vecs.push_back('{0, 8'hAA, 0, 0, 5, 0, 8'h00, 1, 11'b11101010100});
    vecs.push_back('{1, 8'hF4, 0, 0, 0, 1, 8'hFA, 1, 11'b11111110100});
    vecs.push_back('{1, 8'h00, 0, 1, 0, 0, 8'h00, 0, 11'b0});
    for (int i = 0; i < 8; i++) begin
      v.is_rx    = ($urandom_range(0, 1) == 1);
      v.data     = 8'($urandom);
      v.bad_par  = v.is_rx && ($urandom_range(0, 3) == 0);
      v.bad_stop = v.is_rx && ($urandom_range(0, 3) == 0);
      v.inh      = v.is_rx ? 0 : int'($urandom_range(0, 1)) * int'($urandom_range(1, 10));
      v.offer    = 1'b0;
      v.txb      = 8'h00;
      v.exp_ok   = !v.bad_par && !v.bad_stop;
      v.exp_fr   = model_frame(v.data);
      vecs.push_back(v);
    end

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("rst_data_oe", 32'(ps2_data_oe), 0);
    chk("rst_pulses", 32'({tx_done, rx_valid, rx_error}), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    last_rx = 8'h00;

    foreach (vecs[k]) begin
      v = vecs[k];
      if (!v.is_rx) begin
        tx_send(v.data, ok);
        chk("tx_accept", 32'(ok), 1);
        chk("tx_ready_busy", 32'(tx_ready), 0);
        dev_frame(v.inh, fr, nb, lat, nd, rel, rdy);
        if (v.inh != 0) chk("inhibit_release", 32'(rel), 1);
        chk("tx_frame", 32'(fr), 32'(v.exp_fr));
        chk("tx_bits", 32'(nb), 11);
        chk("tx_latency", 32'(lat), 32'(23 * H));
        chk("tx_done_count", 32'(nd), 1);
        chk("tx_ready_after", 32'(rdy), 1);
      end else begin
        host_send(v.data, v.bad_par, v.bad_stop, v.offer, v.txb, nf, ack, gv, ge, lat,
                  rdy_ok, pulse_ok);
        chk("rx_pulses", 32'(nf), 11);
        chk("rx_ack", 32'(ack), 32'(v.exp_ok));
        chk("rx_valid", 32'(gv), 32'(v.exp_ok));
        chk("rx_error", 32'(ge), 32'(!v.exp_ok));
        // Release lands mid-cycle; two synchroniser flops, then the detecting edge.
        chk("rx_latency", 32'(lat), 32'(23 * H + 3));
        chk("rx_one_cycle", 32'(pulse_ok), 1);
        if (v.exp_ok) last_rx = v.data;
        chk("rx_data", 32'(rx_data), 32'(last_rx));
        if (v.offer) begin
          chk("prio_ready", 32'(rdy_ok), 1);
          dev_frame(0, fr, nb, lat, nd, rel, rdy);
          chk("prio_frame", 32'(fr), 32'(v.exp_fr));
          chk("prio_done", 32'(nd), 1);
        end
      end
    end

    // Reset in the middle of a host-to-device frame.
    @(negedge clk);
    host_clk = 1'b0;
    repeat (2 * H) @(negedge clk);
    host_dat = 1'b0;
    repeat (H) @(negedge clk);
    host_clk = 1'b1;
    falls = 0;
    prev_c = 1'b1;
    for (int cyc = 0; cyc < 20 * H && falls < 5; cyc++) begin
      @(negedge clk);
      if (prev_c && !line_clk) falls++;
      prev_c = line_clk;
    end
    chk("rstmid_reached", 32'(falls), 5);
    rst = 1'b1;
    host_dat = 1'b1;
    @(negedge clk);
    chk("rstmid_clk_oe", 32'(ps2_clk_oe), 0);
    chk("rstmid_data_oe", 32'(ps2_data_oe), 0);
    chk("rstmid_tx_ready", 32'(tx_ready), 1);
    rst = 1'b0;
    hits = 0;
    repeat (30 * H) begin
      @(negedge clk);
      if (rx_valid || rx_error) hits++;
    end
    chk("rstmid_no_rx_pulse", 32'(hits), 0);
    chk("rstmid_rx_data", 32'(rx_data), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
